// File: rtl/midi_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : midi_voice_allocator
//  Purpose  : Maps MIDI note events onto VOICES synth voice slots using a
//             serial scan (free > oldest released > oldest held/steal).
//  Revision : 1.0  initial release
// ============================================================================
module midi_voice_allocator #(
    parameter int VOICES  = 128,
    parameter int V_WIDTH = $clog2(VOICES),
    parameter int AGE_W   = 8
) (
    input  logic                CLOCK_25,
    input  logic                reset_reg,
    input  logic [15:0]         ch_enable,
    input  logic                ev_valid,
    output logic                ev_ready,
    input  logic [1:0]          ev_type,
    input  logic [3:0]          ev_ch,
    input  logic [6:0]          ev_key,
    input  logic [6:0]          ev_vel,
    input  logic [VOICES-1:0]   voice_free,
    output logic                note_on,
    output logic                note_evt,
    output logic [VOICES-1:0]   keys_on,
    output logic [V_WIDTH-1:0]  cur_key_adr,
    output logic [7:0]          cur_key_val,
    output logic [7:0]          cur_vel_on,
    output logic [7:0]          cur_vel_off,
    output logic                steal,
    output logic [V_WIDTH:0]    active_keys,
    output logic                off_note_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    localparam logic [1:0] OP_OFF  = 2'd0;
    localparam logic [1:0] OP_ON   = 2'd1;
    localparam logic [1:0] OP_ALL  = 2'd2;

    logic [1:0]         r_state;
    logic [V_WIDTH-1:0] r_idx;
    logic [1:0]         r_op;
    logic [3:0]         r_ch;
    logic [6:0]         r_key;
    logic [6:0]         r_vel;

    logic [VOICES-1:0]  r_keys;
    logic [6:0]         r_vkey  [VOICES];
    logic [3:0]         r_vch   [VOICES];
    logic [AGE_W-1:0]   r_stamp [VOICES];
    logic [AGE_W-1:0]   r_cnt;

    logic               r_hit_v, r_free_v, r_rel_v, r_old_v;
    logic [V_WIDTH-1:0] r_hit_i, r_free_i, r_rel_i, r_old_i;
    logic [AGE_W-1:0]   r_rel_age, r_old_age;

    logic               r_note_on, r_note_evt, r_steal, r_err;
    logic [V_WIDTH-1:0] r_adr;
    logic [7:0]         r_kval, r_von, r_voff;
    logic [V_WIDTH:0]   r_active;

    logic               w_accept, w_drop, w_last;
    logic [1:0]         w_op;
    logic               w_held, w_match;
    logic [AGE_W-1:0]   w_age;
    logic               w_hit_v, w_free_v, w_rel_v, w_old_v;
    logic [V_WIDTH-1:0] w_hit_i, w_free_i, w_rel_i, w_old_i;
    logic [AGE_W-1:0]   w_rel_age, w_old_age;
    logic [V_WIDTH-1:0] w_tgt;
    logic               w_steal;
    logic [V_WIDTH:0]   w_pop;

    assign ev_ready     = (r_state == S_IDLE) & ~reset_reg;
    assign w_accept     = ev_valid & ev_ready;
    assign w_drop       = ~ch_enable[ev_ch] | (ev_type == 2'd3);
    // A note-on with zero velocity is a note-off by MIDI convention
    assign w_op         = (ev_type == OP_ON && ev_vel == 7'd0) ? OP_OFF : ev_type;
    assign w_last       = (r_idx == V_WIDTH'(VOICES - 1));

    assign w_held       = r_keys[r_idx];
    assign w_match      = w_held && (r_vch[r_idx] == r_ch) && (r_vkey[r_idx] == r_key);
    assign w_age        = r_cnt - r_stamp[r_idx];

    // Candidate trackers including the voice examined this cycle
    always_comb begin
        w_hit_v   = r_hit_v;   w_hit_i   = r_hit_i;
        w_free_v  = r_free_v;  w_free_i  = r_free_i;
        w_rel_v   = r_rel_v;   w_rel_i   = r_rel_i;   w_rel_age = r_rel_age;
        w_old_v   = r_old_v;   w_old_i   = r_old_i;   w_old_age = r_old_age;
        if (!r_hit_v && w_match) begin
            w_hit_v = 1'b1;
            w_hit_i = r_idx;
        end
        if (!r_free_v && !w_held && voice_free[r_idx]) begin
            w_free_v = 1'b1;
            w_free_i = r_idx;
        end
        if (!w_held && !voice_free[r_idx] && (!r_rel_v || w_age > r_rel_age)) begin
            w_rel_v   = 1'b1;
            w_rel_i   = r_idx;
            w_rel_age = w_age;
        end
        if (w_held && (!r_old_v || w_age > r_old_age)) begin
            w_old_v   = 1'b1;
            w_old_i   = r_idx;
            w_old_age = w_age;
        end
    end

    always_comb begin
        w_steal = 1'b0;
        if (w_hit_v)       w_tgt = w_hit_i;
        else if (w_free_v) w_tgt = w_free_i;
        else if (w_rel_v)  w_tgt = w_rel_i;
        else begin
            w_tgt   = w_old_i;
            w_steal = 1'b1;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < VOICES; i++)
            w_pop = w_pop + {{V_WIDTH{1'b0}}, r_keys[i]};
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset_reg) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_op       <= OP_OFF;
            r_ch       <= '0;
            r_key      <= '0;
            r_vel      <= '0;
            r_keys     <= '0;
            r_cnt      <= '0;
            for (int i = 0; i < VOICES; i++) begin
                r_vkey[i]  <= '0;
                r_vch[i]   <= '0;
                r_stamp[i] <= '0;
            end
            r_hit_v    <= 1'b0;  r_hit_i  <= '0;
            r_free_v   <= 1'b0;  r_free_i <= '0;
            r_rel_v    <= 1'b0;  r_rel_i  <= '0;  r_rel_age <= '0;
            r_old_v    <= 1'b0;  r_old_i  <= '0;  r_old_age <= '0;
            r_note_on  <= 1'b0;
            r_note_evt <= 1'b0;
            r_steal    <= 1'b0;
            r_err      <= 1'b0;
            r_adr      <= '0;
            r_kval     <= '0;
            r_von      <= '0;
            r_voff     <= '0;
            r_active   <= '0;
        end else begin
            r_note_on  <= 1'b0;
            r_note_evt <= 1'b0;
            r_steal    <= 1'b0;
            r_err      <= 1'b0;
            r_active   <= w_pop;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && !w_drop) begin
                        r_op     <= w_op;
                        r_ch     <= ev_ch;
                        r_key    <= ev_key;
                        r_vel    <= ev_vel;
                        r_idx    <= '0;
                        r_hit_v  <= 1'b0;
                        r_free_v <= 1'b0;
                        r_rel_v  <= 1'b0;
                        r_old_v  <= 1'b0;
                        r_state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_hit_v  <= w_hit_v;   r_hit_i  <= w_hit_i;
                    r_free_v <= w_free_v;  r_free_i <= w_free_i;
                    r_rel_v  <= w_rel_v;   r_rel_i  <= w_rel_i;   r_rel_age <= w_rel_age;
                    r_old_v  <= w_old_v;   r_old_i  <= w_old_i;   r_old_age <= w_old_age;
                    if (!w_last) begin
                        r_idx <= r_idx + V_WIDTH'(1);
                    end else begin
                        // Results land on the edge into ISSUE so pulses are seen there
                        r_state <= S_ISSUE;
                        case (r_op)
                            OP_ON: begin
                                r_keys[w_tgt]  <= 1'b1;
                                r_vch[w_tgt]   <= r_ch;
                                r_vkey[w_tgt]  <= r_key;
                                r_stamp[w_tgt] <= r_cnt;
                                r_cnt          <= r_cnt + AGE_W'(1);
                                r_note_on      <= 1'b1;
                                r_note_evt     <= 1'b1;
                                r_steal        <= w_steal;
                                r_adr          <= w_tgt;
                                r_kval         <= {1'b0, r_key};
                                r_von          <= {1'b0, r_vel};
                            end
                            OP_OFF: begin
                                if (w_hit_v) begin
                                    r_keys[w_hit_i] <= 1'b0;
                                    r_note_evt      <= 1'b1;
                                    r_adr           <= w_hit_i;
                                    r_kval          <= {1'b0, r_key};
                                    r_voff          <= {1'b0, r_vel};
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                            default: begin
                                for (int i = 0; i < VOICES; i++)
                                    if (r_keys[i] && r_vch[i] == r_ch)
                                        r_keys[i] <= 1'b0;
                            end
                        endcase
                    end
                end
                S_ISSUE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign note_on      = r_note_on;
    assign note_evt     = r_note_evt;
    assign keys_on      = r_keys;
    assign cur_key_adr  = r_adr;
    assign cur_key_val  = r_kval;
    assign cur_vel_on   = r_von;
    assign cur_vel_off  = r_voff;
    assign steal        = r_steal;
    assign active_keys  = r_active;
    assign off_note_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_midi_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_midi_voice_allocator
//  Purpose  : Scoreboard bench for midi_voice_allocator with a reference
//             allocation model using unbounded note ages.
//  Revision : 1.0  initial release
// ============================================================================
module tb_midi_voice_allocator;

    localparam int VOICES = 8;
    localparam int VW     = 3;
    localparam int AGE_W  = 8;

    logic              CLOCK_25 = 1'b0;
    logic              reset_reg;
    logic [15:0]       ch_enable;
    logic              ev_valid;
    logic              ev_ready;
    logic [1:0]        ev_type;
    logic [3:0]        ev_ch;
    logic [6:0]        ev_key;
    logic [6:0]        ev_vel;
    logic [VOICES-1:0] voice_free;
    logic              note_on, note_evt, steal, off_note_err;
    logic [VOICES-1:0] keys_on;
    logic [VW-1:0]     cur_key_adr;
    logic [7:0]        cur_key_val, cur_vel_on, cur_vel_off;
    logic [VW:0]       active_keys;

    midi_voice_allocator #(.VOICES(VOICES), .V_WIDTH(VW), .AGE_W(AGE_W)) dut (
        .CLOCK_25(CLOCK_25), .reset_reg(reset_reg), .ch_enable(ch_enable),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
        .ev_ch(ev_ch), .ev_key(ev_key), .ev_vel(ev_vel), .voice_free(voice_free),
        .note_on(note_on), .note_evt(note_evt), .keys_on(keys_on),
        .cur_key_adr(cur_key_adr), .cur_key_val(cur_key_val),
        .cur_vel_on(cur_vel_on), .cur_vel_off(cur_vel_off), .steal(steal),
        .active_keys(active_keys), .off_note_err(off_note_err)
    );

    always #5 CLOCK_25 = ~CLOCK_25;

    int cyc = 0;
    always @(posedge CLOCK_25) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         err;
        bit         on;
        logic [VW-1:0] adr;
        logic [6:0] key;
        logic [6:0] vel;
        bit         stl;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   last_ready_after;
    int   last_v;
    bit   last_stl;

    bit   m_held  [VOICES];
    int   m_ch    [VOICES];
    int   m_key   [VOICES];
    int   m_stamp [VOICES];
    int   m_cnt;

    function automatic logic [VOICES-1:0] model_keys();
        logic [VOICES-1:0] r;
        for (int i = 0; i < VOICES; i++) r[i] = m_held[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < VOICES; i++) begin
            m_held[i] = 0; m_ch[i] = 0; m_key[i] = 0; m_stamp[i] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic model_on(input int ch, input int key, output int v, output bit stl);
        int hit = -1, fr = -1, rel = -1, old = -1;
        int rel_age = 0, old_age = 0, age;
        for (int i = 0; i < VOICES; i++) begin
            age = m_cnt - m_stamp[i];
            if (m_held[i] && m_ch[i] == ch && m_key[i] == key && hit < 0) hit = i;
            if (!m_held[i] && voice_free[i] && fr < 0) fr = i;
            if (!m_held[i] && !voice_free[i] && (rel < 0 || age > rel_age)) begin rel = i; rel_age = age; end
            if (m_held[i] && (old < 0 || age > old_age)) begin old = i; old_age = age; end
        end
        stl = 0;
        if (hit >= 0)     v = hit;
        else if (fr >= 0) v = fr;
        else if (rel >= 0) v = rel;
        else begin v = old; stl = 1; end
        m_held[v] = 1; m_ch[v] = ch; m_key[v] = key; m_stamp[v] = m_cnt;
        m_cnt++;
    endtask

    // Scoreboard pop/compare for any allocator pulse seen this cycle
    task automatic collect();
        exp_t e;
        bit   ok;
        if (note_evt || off_note_err) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse cyc=%0d note_evt=%b off_note_err=%b adr=%0d expected no pulse",
                         cyc, note_evt, off_note_err, cur_key_adr);
            end else begin
                e = q.pop_front();
                if (e.err)
                    ok = (off_note_err === 1'b1) && (note_evt === 1'b0) && (cyc == e.cyc);
                else
                    ok = (note_evt === 1'b1) && (off_note_err === 1'b0) && (note_on === e.on) &&
                         (steal === e.stl) && (cur_key_adr === e.adr) &&
                         (cur_key_val === {1'b0, e.key}) && (cyc == e.cyc) &&
                         ((e.on ? cur_vel_on : cur_vel_off) === {1'b0, e.vel});
                if (!ok) begin
                    fails++;
                    $display("FAIL event cyc=%0d evt=%b err=%b on=%b steal=%b adr=%0d key=%0d von=%0d voff=%0d expected cyc=%0d err=%b on=%b steal=%b adr=%0d key=%0d vel=%0d",
                             cyc, note_evt, off_note_err, note_on, steal, cur_key_adr, cur_key_val,
                             cur_vel_on, cur_vel_off, e.cyc, e.err, e.on, e.stl, e.adr, e.key, e.vel);
                end
            end
        end
    endtask

    task automatic send(input logic [1:0] t, input int ch, input int key, input int vel, input bit wait_done);
        int   guard = 0;
        int   c;
        bit   dropped;
        int   v;
        bit   stl, found;
        exp_t e;
        @(negedge CLOCK_25);
        while (!ev_ready && guard < 4 * VOICES) begin
            @(negedge CLOCK_25);
            guard++;
        end
        if (!ev_ready) begin
            tests++; fails++;
            $display("FAIL ready_timeout ev_ready=%b expected 1", ev_ready);
            return;
        end
        ev_type = t; ev_ch = 4'(ch); ev_key = 7'(key); ev_vel = 7'(vel); ev_valid = 1'b1;
        c = cyc;
        dropped = !ch_enable[ch] || t == 2'd3;
        e.cyc = c + VOICES + 1; e.err = 0; e.on = 0; e.stl = 0; e.key = 7'(key); e.vel = 7'(vel); e.adr = '0;
        if (!dropped) begin
            if (t == 2'd1 && vel != 0) begin
                model_on(ch, key, v, stl);
                last_v = v; last_stl = stl;
                e.on = 1; e.adr = VW'(v); e.stl = stl;
                q.push_back(e);
            end else if (t == 2'd2) begin
                for (int i = 0; i < VOICES; i++)
                    if (m_held[i] && m_ch[i] == ch) m_held[i] = 0;
            end else begin
                found = 0;
                for (int i = 0; i < VOICES; i++)
                    if (!found && m_held[i] && m_ch[i] == ch && m_key[i] == key) begin
                        found = 1; m_held[i] = 0; e.adr = VW'(i);
                    end
                e.err = !found;
                q.push_back(e);
            end
        end
        @(negedge CLOCK_25);
        ev_valid = 1'b0;
        last_ready_after = ev_ready;
        if (!wait_done) return;
        for (int i = 0; i < VOICES + 3; i++) begin
            @(negedge CLOCK_25);
            collect();
        end
        tests++;
        if (q.size() !== 0) begin
            fails++;
            $display("FAIL missing_pulse pending=%0d expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK_25);
        reset_reg = 1'b1; ev_valid = 1'b0;
        repeat (2) @(negedge CLOCK_25);
        reset_reg = 1'b0;
        model_reset();
        q.delete();
    endtask

    task automatic test_reset();
        @(negedge CLOCK_25);
        reset_reg = 1'b1;
        repeat (2) @(negedge CLOCK_25);
        tests++;
        if ({ev_ready, note_on, note_evt, keys_on, cur_key_adr, cur_key_val, cur_vel_on,
             cur_vel_off, steal, active_keys, off_note_err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs ready=%b keys=%h adr=%0d active=%0d expected all zero",
                     ev_ready, keys_on, cur_key_adr, active_keys);
        end
        reset_reg = 1'b0;
        model_reset();
        #1;
        tests++;
        if (ev_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready ev_ready=%b expected 1", ev_ready);
        end
    endtask

    task automatic test_first_note();
        do_reset();
        ch_enable = 16'h0001; voice_free = '1;
        send(2'd1, 0, 60, 100, 1);
        tests++;
        if (keys_on !== 8'h01 || active_keys !== 4'd1 || cur_key_adr !== 3'd0 || last_ready_after !== 1'b0) begin
            fails++;
            $display("FAIL first_note keys=%h active=%0d adr=%0d ready_after=%b expected 01 1 0 0",
                     keys_on, active_keys, cur_key_adr, last_ready_after);
        end
    endtask

    task automatic test_steal();
        do_reset();
        ch_enable = 16'h0001; voice_free = '1;
        for (int k = 0; k <= VOICES; k++) begin
            send(2'd1, 0, k, 40 + k, 1);
            voice_free[last_v] = 1'b0;
        end
        tests++;
        if (cur_key_adr !== 3'd0 || cur_key_val !== 8'(VOICES) || keys_on !== 8'hFF) begin
            fails++;
            $display("FAIL steal_oldest adr=%0d key=%0d keys=%h expected 0 %0d ff",
                     cur_key_adr, cur_key_val, keys_on, VOICES);
        end
    endtask

    task automatic test_off_unmatched();
        send(2'd0, 0, 61, 10, 1);
        tests++;
        if (keys_on !== model_keys()) begin
            fails++;
            $display("FAIL off_unmatched_keys keys=%h expected %h", keys_on, model_keys());
        end
    endtask

    task automatic test_vel0_off();
        do_reset();
        ch_enable = 16'h0001; voice_free = '1;
        send(2'd1, 0, 60, 100, 1);
        send(2'd1, 0, 60, 90, 1);
        send(2'd1, 0, 60, 0, 1);
        tests++;
        if (keys_on !== 8'h00 || cur_vel_off !== 8'd0 || cur_vel_on !== 8'd90) begin
            fails++;
            $display("FAIL vel0_off keys=%h voff=%0d von=%0d expected 00 0 90", keys_on, cur_vel_off, cur_vel_on);
        end
    endtask

    task automatic test_all_off_and_drop();
        do_reset();
        ch_enable = 16'h000D; voice_free = '1;
        send(2'd1, 2, 10, 50, 1);
        send(2'd1, 2, 11, 51, 1);
        send(2'd1, 3, 12, 52, 1);
        send(2'd2, 2, 0, 0, 1);
        tests++;
        if (keys_on !== 8'h04 || active_keys !== 4'd1) begin
            fails++;
            $display("FAIL all_notes_off keys=%h active=%0d expected 04 1", keys_on, active_keys);
        end
        send(2'd1, 5, 20, 80, 1);
        tests++;
        if (last_ready_after !== 1'b1 || keys_on !== 8'h04) begin
            fails++;
            $display("FAIL drop_disabled ready_after=%b keys=%h expected 1 04", last_ready_after, keys_on);
        end
        send(2'd3, 0, 21, 80, 1);
        tests++;
        if (last_ready_after !== 1'b1 || keys_on !== 8'h04) begin
            fails++;
            $display("FAIL drop_reserved ready_after=%b keys=%h expected 1 04", last_ready_after, keys_on);
        end
    endtask

    task automatic test_reset_midscan();
        bit seen = 0;
        do_reset();
        ch_enable = 16'h0001; voice_free = '1;
        send(2'd1, 0, 30, 70, 0);
        repeat (2) @(negedge CLOCK_25);
        reset_reg = 1'b1;
        q.delete();
        model_reset();
        repeat (2) begin
            @(negedge CLOCK_25);
            if (note_evt || off_note_err || note_on) seen = 1;
        end
        reset_reg = 1'b0;
        #1;
        tests++;
        if (ev_ready !== 1'b1 || keys_on !== 8'h00) begin
            fails++;
            $display("FAIL midscan_reset ready=%b keys=%h expected 1 00", ev_ready, keys_on);
        end
        for (int i = 0; i < VOICES + 3; i++) begin
            @(negedge CLOCK_25);
            if (note_evt || off_note_err || note_on) seen = 1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL midscan_no_pulse seen=%b expected 0", seen);
        end
    endtask

    task automatic test_wrap();
        voice_free = '0;
        for (int i = 0; i < 300; i++)
            send(2'd1, 0, i % 128, 1 + (i % 127), 1);
        tests++;
        if (keys_on !== 8'hFF || steal !== 1'b0 || cur_key_adr !== VW'(last_v)) begin
            fails++;
            $display("FAIL wrap_final keys=%h adr=%0d expected ff %0d", keys_on, cur_key_adr, last_v);
        end
    endtask

    task automatic test_back_to_back();
        int t, ch, key, vel;
        do_reset();
        ch_enable = 16'h0003;
        for (int i = 0; i < 40; i++) begin
            voice_free = VOICES'($urandom);
            t   = ($urandom_range(0, 2) == 0) ? 0 : 1;
            ch  = $urandom_range(0, 1);
            key = $urandom_range(60, 65);
            vel = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 127);
            send(2'(t), ch, key, vel, 1);
        end
        tests++;
        if (keys_on !== model_keys()) begin
            fails++;
            $display("FAIL random_keys keys=%h expected %h", keys_on, model_keys());
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog cyc=%0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_reg = 1'b1; ev_valid = 1'b0; ev_type = '0; ev_ch = '0; ev_key = '0; ev_vel = '0;
        ch_enable = '0; voice_free = '0;
        model_reset();
        test_reset();
        test_first_note();
        test_steal();
        test_off_unmatched();
        test_vel0_off();
        test_all_off_and_drop();
        test_reset_midscan();
        test_wrap();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
